edge_window_counter: RTL and testbench

Multi-channel gated event counter for the PLL simulation benches. It counts rising edges or high cycles on up to CHANNELS independent input signals during a programmable window of clk cycles, then publishes all results simultaneously with a done pulse. It replaces free-running per-signal counters where the bench needs windowed frequency or duty-cycle measurement against a reference clock.

---
 rtl/edge_window_counter.sv | 247 ++++++++++++++++++++++++
 tb/tb_edge_window_counter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_window_counter.sv
// ---------------------------------------------------------------------------
// edge_window_counter
//
// Multi-channel gated event counter. It counts rising edges (mode=0) or high
// cycles (mode=1) on CHANNELS input signals over a window of window_len clk
// cycles. At the end of the window it publishes every channel's result at
// once and pulses done.
//
// Optional feature macro: EDGE_WINDOW_COUNTER_SYNC_EN
//   defined     : each sig_in bit goes through a two-flop synchroniser
//                 (sig_in -> s latency 2 clk), safe for asynchronous inputs.
//   not defined : a single register stage (latency 1 clk); sig_in must be
//                 synchronous to clk.
//
// Ports
//   clk        in   reference / sampling clock
//   rst        in   asynchronous active-high reset
//   start      in   measurement request, sampled on posedge clk
//   window_len in   window length N in clk cycles, latched on accepted start
//   mode       in   0 = count rising edges, 1 = count high cycles (latched)
//   sig_in     in   measured signals
//   busy       out  window in progress
//   done       out  one-cycle pulse, counts/overflow updated this cycle
//   counts     out  results, channel i at [i*WIDTH +: WIDTH]
//   overflow   out  channel i saturated during the last window
//   dbg_state  out  current FSM state (0 = IDLE, 1 = COUNT)
//
// Request protocol: start acts as a valid with an implicit ready equal to
// ~busy. A start seen while IDLE is accepted on that edge; a start seen
// while COUNT is dropped (no restart, no queueing). Each accepted start
// yields exactly one done pulse, N+1 edges later (1 edge later for N=0),
// unless reset aborts the window.
// ---------------------------------------------------------------------------
module edge_window_counter #(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int WINDOW_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [WINDOW_W-1:0]       window_len,
   input  logic                      mode,
   input  logic [CHANNELS-1:0]       sig_in,
   output logic                      busy,
   output logic                      done,
   output logic [CHANNELS*WIDTH-1:0] counts,
   output logic [CHANNELS-1:0]       overflow,
   output logic                      dbg_state
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_COUNT = 1'b1
   } state_t;

   localparam logic [WIDTH-1:0] ACC_MAX = {WIDTH{1'b1}};

   // ------------------------------------------------------------------
   // Input sampling stage
   // ------------------------------------------------------------------
   logic [CHANNELS-1:0] s;
   logic [CHANNELS-1:0] s_prev_q;

`ifdef EDGE_WINDOW_COUNTER_SYNC_EN
   logic [CHANNELS-1:0] sync1_q;
   logic [CHANNELS-1:0] sync2_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sig_in;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   logic [CHANNELS-1:0] samp_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_q <= '0;
      end else begin
         samp_q <= sig_in;
      end
   end

   assign s = samp_q;
`endif

   // The previous-sample register runs continuously, so the first cycle of
   // a window already has a valid history for rising-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_prev_q <= '0;
      end else begin
         s_prev_q <= s;
      end
   end

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t                            state_q, state_d;
   logic [WINDOW_W-1:0]               rem_q, rem_d;
   logic                              mode_q, mode_d;
   logic                              done_q, done_d;
   logic [CHANNELS-1:0][WIDTH-1:0]    acc_q, acc_d;
   logic [CHANNELS-1:0]               ovf_acc_q, ovf_acc_d;
   logic [CHANNELS-1:0][WIDTH-1:0]    counts_q, counts_d;
   logic [CHANNELS-1:0]               overflow_q, overflow_d;

   // FSM control strobes
   logic clr_acc;    // start of a new window
   logic acc_en;     // accumulate this cycle's events
   logic load_res;   // publish accumulators (including this cycle's events)
   logic zero_res;   // zero-length request: publish all-zero result

   // ------------------------------------------------------------------
   // FSM next-state / control
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      mode_d   = mode_q;
      done_d   = 1'b0;
      clr_acc  = 1'b0;
      acc_en   = 1'b0;
      load_res = 1'b0;
      zero_res = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (window_len != '0) begin
                  rem_d   = window_len;
                  mode_d  = mode;
                  clr_acc = 1'b1;
                  state_d = S_COUNT;
               end else begin
                  zero_res = 1'b1;
                  done_d   = 1'b1;
               end
            end
         end

         S_COUNT: begin
            acc_en = 1'b1;
            rem_d  = rem_q - WINDOW_W'(1);
            if (rem_q == WINDOW_W'(1)) begin
               load_res = 1'b1;
               done_d   = 1'b1;
               state_d  = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Per-channel event detection and saturating accumulate
   // ------------------------------------------------------------------
   logic [CHANNELS-1:0]            evt;
   logic [CHANNELS-1:0][WIDTH-1:0] acc_nx;
   logic [CHANNELS-1:0]            ovf_nx;

   always_comb begin
      evt    = '0;
      acc_nx = acc_q;
      ovf_nx = ovf_acc_q;
      for (int i = 0; i < CHANNELS; i++) begin
         evt[i] = mode_q ? s[i] : (s[i] & ~s_prev_q[i]);
         if (evt[i]) begin
            // At full scale the event is lost: hold max and flag overflow.
            if (acc_q[i] == ACC_MAX) begin
               ovf_nx[i] = 1'b1;
            end else begin
               acc_nx[i] = acc_q[i] + WIDTH'(1);
            end
         end
      end
   end

   always_comb begin
      acc_d      = acc_q;
      ovf_acc_d  = ovf_acc_q;
      counts_d   = counts_q;
      overflow_d = overflow_q;

      if (clr_acc) begin
         acc_d     = '0;
         ovf_acc_d = '0;
      end else if (acc_en) begin
         acc_d     = acc_nx;
         ovf_acc_d = ovf_nx;
      end

      if (load_res) begin
         counts_d   = acc_nx;
         overflow_d = ovf_nx;
      end else if (zero_res) begin
         counts_d   = '0;
         overflow_d = '0;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         mode_q     <= 1'b0;
         done_q     <= 1'b0;
         acc_q      <= '0;
         ovf_acc_q  <= '0;
         counts_q   <= '0;
         overflow_q <= '0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         mode_q     <= mode_d;
         done_q     <= done_d;
         acc_q      <= acc_d;
         ovf_acc_q  <= ovf_acc_d;
         counts_q   <= counts_d;
         overflow_q <= overflow_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign busy      = (state_q == S_COUNT);
   assign done      = done_q;
   assign counts    = counts_q;
   assign overflow  = overflow_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_edge_window_counter.sv
// ---------------------------------------------------------------------------
// tb_edge_window_counter
//
// Bench for edge_window_counter. Two instances share clk/rst/window_len/mode/
// sig_in: u_dut_a uses the default WIDTH=32, u_dut_b uses WIDTH=4 for the
// saturation scenarios. Expected results are pushed onto exp_q when a start
// is driven and popped when the matching done is observed. Inputs are driven
// and outputs sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_edge_window_counter;

   localparam int CH    = 4;
   localparam int W_A   = 32;
   localparam int W_B   = 4;
   localparam int WW    = 16;
   localparam int EXP_W = CH * W_A + CH;

   logic              clk;
   logic              rst;
   logic              start_a;
   logic              start_b;
   logic              mode;
   logic [WW-1:0]     window_len;
   logic [CH-1:0]     sig_man;
   logic [CH-1:0]     sig_gen = '0;
   logic [CH-1:0]     sig_in;

   logic              busy_a, done_a, dbg_state_a;
   logic [CH*W_A-1:0] counts_a;
   logic [CH-1:0]     overflow_a;
   logic              busy_b, done_b, dbg_state_b;
   logic [CH*W_B-1:0] counts_b;
   logic [CH-1:0]     overflow_b;

   logic [EXP_W-1:0]  exp_q[$];
   int                vectors     = 0;
   int                miscompares = 0;
   bit                gen_en      = 1'b0;
   int                gen_cnt     = 0;

   assign sig_in = sig_man | sig_gen;

   edge_window_counter #(.CHANNELS(CH), .WIDTH(W_A), .WINDOW_W(WW)) u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .start      (start_a),
      .window_len (window_len),
      .mode       (mode),
      .sig_in     (sig_in),
      .busy       (busy_a),
      .done       (done_a),
      .counts     (counts_a),
      .overflow   (overflow_a),
      .dbg_state  (dbg_state_a)
   );

   edge_window_counter #(.CHANNELS(CH), .WIDTH(W_B), .WINDOW_W(WW)) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .start      (start_b),
      .window_len (window_len),
      .mode       (mode),
      .sig_in     (sig_in),
      .busy       (busy_b),
      .done       (done_b),
      .counts     (counts_b),
      .overflow   (overflow_b),
      .dbg_state  (dbg_state_b)
   );

   // ------------------------------------------------------------------
   // Clock and reset
   // ------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Periodic synchronous patterns: ch1 period 4 (2 high / 2 low),
   // ch2 period 8 (4 high / 4 low).
   always @(negedge clk) begin
      if (gen_en) begin
         gen_cnt = gen_cnt + 1;
         sig_gen = {1'b0, ((gen_cnt % 8) < 4), ((gen_cnt % 4) < 2), 1'b0};
      end else begin
         gen_cnt = 0;
         sig_gen = '0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

   // ------------------------------------------------------------------
   // Expected-value packing: {overflow, ch3, ch2, ch1, ch0}
   // ------------------------------------------------------------------
   function automatic logic [EXP_W-1:0] pack_a(input logic [W_A-1:0] c0, input logic [W_A-1:0] c1,
                                                input logic [W_A-1:0] c2, input logic [W_A-1:0] c3,
                                                input logic [CH-1:0] ov);
      return {ov, c3, c2, c1, c0};
   endfunction

   function automatic logic [EXP_W-1:0] pack_b(input logic [W_B-1:0] c0, input logic [W_B-1:0] c1,
                                                input logic [W_B-1:0] c2, input logic [W_B-1:0] c3,
                                                input logic [CH-1:0] ov);
      return EXP_W'({ov, c3, c2, c1, c0});
   endfunction

   // ------------------------------------------------------------------
   // Driver helpers
   // ------------------------------------------------------------------
   task automatic settle(input logic [CH-1:0] lvl);
      sig_man = lvl;
      repeat (4) @(negedge clk);
   endtask

   // Waits (bounded) for done on the selected instance; start is dropped
   // after the first edge. lat counts edges from the start edge.
   task automatic wait_done(input bit use_b, input int budget, output int lat,
                            output bit seen, output bit busy_seen);
      lat       = 0;
      seen      = 1'b0;
      busy_seen = 1'b0;
      while (!seen && lat < budget) begin
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         lat++;
         if (use_b ? busy_b : busy_a) busy_seen = 1'b1;
         if (use_b ? done_b : done_a) seen = 1'b1;
      end
   endtask

   // ------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------
   task automatic test_reset();
      rst        = 1'b1;
      start_a    = 1'b0;
      start_b    = 1'b0;
      mode       = 1'b0;
      window_len = '0;
      sig_man    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || dbg_state_a !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: busy=%b done=%b state=%b, want 0 0 0", busy_a, done_a, dbg_state_a);
      end
      vectors++;
      if ({overflow_a, counts_a} !== '0) begin
         miscompares++;
         $display("FAIL reset_result_a: got %h, want 0", {overflow_a, counts_a});
      end
      vectors++;
      if ({busy_b, done_b, overflow_b, counts_b} !== '0) begin
         miscompares++;
         $display("FAIL reset_b: got %h, want 0", {busy_b, done_b, overflow_b, counts_b});
      end
   endtask

   task automatic test_high_count();
      int lat;
      bit seen, bsy;
      logic [EXP_W-1:0] exp_v;
      settle(4'b0001);
      start_a    = 1'b1;
      window_len = 16'd10;
      mode       = 1'b1;
      exp_q.push_back(pack_a(32'd10, 32'd0, 32'd0, 32'd0, 4'b0000));
      wait_done(1'b0, 30, lat, seen, bsy);
      exp_v = exp_q.pop_front();
      vectors++;
      if (!seen || lat != 11 || !bsy) begin
         miscompares++;
         $display("FAIL high_latency: edges=%0d seen=%0b busy_seen=%0b, want 11 1 1", lat, seen, bsy);
      end
      vectors++;
      if (busy_a !== 1'b0) begin
         miscompares++;
         $display("FAIL high_busy_at_done: busy=%b, want 0", busy_a);
      end
      vectors++;
      if ({overflow_a, counts_a} !== exp_v) begin
         miscompares++;
         $display("FAIL high_result: got %h, want %h", {overflow_a, counts_a}, exp_v);
      end
   endtask

   task automatic test_edge_count();
      int lat;
      bit seen, bsy;
      logic [EXP_W-1:0] exp_v;
      sig_man = '0;
      gen_en  = 1'b1;
      repeat (10) @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         start_a    = 1'b1;
         window_len = 16'd16;
         mode       = m[0];
         if (m == 0) exp_q.push_back(pack_a(32'd0, 32'd4, 32'd2, 32'd0, 4'b0000));
         else        exp_q.push_back(pack_a(32'd0, 32'd8, 32'd8, 32'd0, 4'b0000));
         wait_done(1'b0, 40, lat, seen, bsy);
         exp_v = exp_q.pop_front();
         vectors++;
         if (!seen || lat != 17) begin
            miscompares++;
            $display("FAIL edge_latency_m%0d: edges=%0d seen=%0b, want 17", m, lat, seen);
         end
         vectors++;
         if ({overflow_a, counts_a} !== exp_v) begin
            miscompares++;
            $display("FAIL edge_result_m%0d: got %h, want %h", m, {overflow_a, counts_a}, exp_v);
         end
      end
      gen_en = 1'b0;
   endtask

   task automatic test_saturate();
      int lat;
      bit seen, bsy;
      logic [EXP_W-1:0] exp_v;
      int lens[3] = '{15, 16, 20};
      settle(4'b0001);
      for (int k = 0; k < 3; k++) begin
         start_b    = 1'b1;
         window_len = WW'(lens[k]);
         mode       = 1'b1;
         exp_q.push_back(pack_b(4'd15, 4'd0, 4'd0, 4'd0, (lens[k] > 15) ? 4'b0001 : 4'b0000));
         wait_done(1'b1, 40, lat, seen, bsy);
         exp_v = exp_q.pop_front();
         vectors++;
         if (!seen || lat != lens[k] + 1) begin
            miscompares++;
            $display("FAIL sat_latency_n%0d: edges=%0d seen=%0b, want %0d", lens[k], lat, seen, lens[k] + 1);
         end
         vectors++;
         if (EXP_W'({overflow_b, counts_b}) !== exp_v) begin
            miscompares++;
            $display("FAIL sat_result_n%0d: got %h, want %h", lens[k], {overflow_b, counts_b}, exp_v);
         end
      end
   endtask

   task automatic test_zero_len();
      int lat;
      bit seen, bsy;
      logic [EXP_W-1:0] exp_v;
      start_a    = 1'b1;
      window_len = 16'd0;
      mode       = 1'b1;
      exp_q.push_back(pack_a(32'd0, 32'd0, 32'd0, 32'd0, 4'b0000));
      wait_done(1'b0, 10, lat, seen, bsy);
      exp_v = exp_q.pop_front();
      vectors++;
      if (!seen || lat != 1 || bsy) begin
         miscompares++;
         $display("FAIL zero_latency: edges=%0d seen=%0b busy_seen=%0b, want 1 1 0", lat, seen, bsy);
      end
      vectors++;
      if ({overflow_a, counts_a} !== exp_v) begin
         miscompares++;
         $display("FAIL zero_result: got %h, want %h", {overflow_a, counts_a}, exp_v);
      end
      // Two consecutive zero-length requests give two consecutive done pulses.
      start_a = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (c == 1) start_a = 1'b0;
         vectors++;
         if (done_a !== (c < 2) || busy_a !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_b2b_c%0d: done=%b busy=%b, want %b 0", c, done_a, busy_a, (c < 2));
         end
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      int done_cnt;
      logic [EXP_W-1:0] exp_v;
      settle(4'b0010);
      start_a    = 1'b1;
      window_len = 16'd10;
      mode       = 1'b1;
      exp_q.push_back(pack_a(32'd0, 32'd10, 32'd0, 32'd0, 4'b0000));
      lat      = 0;
      done_cnt = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (done_a) begin
            done_cnt++;
            if (lat == 0) begin
               lat   = c;
               exp_v = exp_q.pop_front();
               vectors++;
               if ({overflow_a, counts_a} !== exp_v) begin
                  miscompares++;
                  $display("FAIL ignore_result: got %h, want %h", {overflow_a, counts_a}, exp_v);
               end
            end
         end
         // Stray requests inside the window, with different parameters.
         start_a    = (c == 3 || c == 6);
         window_len = (c == 3 || c == 6) ? 16'd3 : 16'd10;
         mode       = (c == 3 || c == 6) ? 1'b0 : 1'b1;
      end
      vectors++;
      if (lat != 11 || done_cnt != 1) begin
         miscompares++;
         $display("FAIL ignore_done: first at %0d, count %0d, want 11 and 1", lat, done_cnt);
      end
      if (lat == 0) void'(exp_q.pop_front());
   endtask

   task automatic test_reset_mid();
      int lat;
      int done_cnt;
      bit seen, bsy;
      logic [EXP_W-1:0] exp_v;
      settle(4'b0001);
      start_a    = 1'b1;
      window_len = 16'd10;
      mode       = 1'b1;
      repeat (5) begin
         @(negedge clk);
         start_a = 1'b0;
      end
      rst = 1'b1;
      #1;
      vectors++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || {overflow_a, counts_a} !== '0) begin
         miscompares++;
         $display("FAIL midreset_clear: busy=%b done=%b result=%h, want 0 0 0", busy_a, done_a, {overflow_a, counts_a});
      end
      @(negedge clk);
      rst      = 1'b0;
      done_cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (done_a || busy_a) done_cnt++;
      end
      vectors++;
      if (done_cnt != 0) begin
         miscompares++;
         $display("FAIL midreset_quiet: %0d cycles with done/busy, want 0", done_cnt);
      end
      start_a    = 1'b1;
      window_len = 16'd4;
      exp_q.push_back(pack_a(32'd4, 32'd0, 32'd0, 32'd0, 4'b0000));
      wait_done(1'b0, 20, lat, seen, bsy);
      exp_v = exp_q.pop_front();
      vectors++;
      if (!seen || lat != 5 || {overflow_a, counts_a} !== exp_v) begin
         miscompares++;
         $display("FAIL midreset_restart: edges=%0d seen=%0b result=%h, want 5 1 %h", lat, seen, {overflow_a, counts_a}, exp_v);
      end
   endtask

   task automatic test_back_to_back();
      int done_cnt;
      logic [EXP_W-1:0] exp_v;
      settle(4'b0001);
      for (int k = 0; k < 3; k++) exp_q.push_back(pack_a(32'd3, 32'd0, 32'd0, 32'd0, 4'b0000));
      start_a    = 1'b1;
      window_len = 16'd3;
      mode       = 1'b1;
      done_cnt   = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 12) start_a = 1'b0;
         vectors++;
         if (done_a !== ((c % 4) == 0)) begin
            miscompares++;
            $display("FAIL b2b_done_c%0d: done=%b, want %b", c, done_a, ((c % 4) == 0));
         end
         if (done_a && exp_q.size() != 0) begin
            done_cnt++;
            exp_v = exp_q.pop_front();
            vectors++;
            if ({overflow_a, counts_a} !== exp_v) begin
               miscompares++;
               $display("FAIL b2b_result_%0d: got %h, want %h", done_cnt, {overflow_a, counts_a}, exp_v);
            end
         end
      end
      while (exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge clk);
   endtask

   task automatic test_random();
      int lat;
      bit seen, bsy;
      int n;
      logic [CH-1:0] lvl;
      logic m;
      logic [W_A-1:0] c [CH];
      logic [EXP_W-1:0] exp_v;
      for (int it = 0; it < 6; it++) begin
         lvl = CH'($urandom_range(0, 15));
         m   = 1'($urandom_range(0, 1));
         n   = $urandom_range(1, 40);
         settle(lvl);
         for (int i = 0; i < CH; i++) c[i] = (m && lvl[i]) ? W_A'(n) : '0;
         start_a    = 1'b1;
         window_len = WW'(n);
         mode       = m;
         exp_q.push_back(pack_a(c[0], c[1], c[2], c[3], 4'b0000));
         wait_done(1'b0, 60, lat, seen, bsy);
         exp_v = exp_q.pop_front();
         vectors++;
         if (!seen || lat != n + 1 || {overflow_a, counts_a} !== exp_v) begin
            miscompares++;
            $display("FAIL random_%0d: edges=%0d seen=%0b result=%h, want %0d 1 %h", it, lat, seen, {overflow_a, counts_a}, n + 1, exp_v);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Sequence and report
   // ------------------------------------------------------------------
   initial begin
      test_reset();
      test_high_count();
      test_edge_count();
      test_saturate();
      test_zero_len();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
